// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link timing.
// The transmitter uses the same constants, so both ends agree on baud and frame size.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter with synchronous clear; flags the half-bit and last-cycle points.
// It wraps on its own at the end of every bit period.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  logic [CNT_W-1:0] clk_cnt;

  assign half_tick = (clk_cnt == CNT_W'(HALF - 1));
  assign full_tick = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt <= '0;
    end else if (clear || full_tick) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: the input is synchronised, bits are sampled at mid-bit, and the byte is
// handed over with valid/ready. Frame and overrun errors are reported as one-cycle pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 cnt_clear;
  logic                 half_tick;
  logic                 full_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Hold the counter at zero while waiting for an edge, then restart it at the start-bit centre
  // so that every later full tick lands at mid-bit.
  assign cnt_clear = (state == IDLE) || (state == BREAK) || ((state == START) && half_tick);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (half_tick) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (full_tick) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (full_tick) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A byte accepted in this same cycle frees the slot, so the new byte is not an overrun.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
